// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: RX pin plus received-byte/valid/error/busy bundle
// master = deserialiser side, slave = line driver and byte consumer side
interface uart_rx_deser_if;
    logic       i_rx;
    logic [7:0] o_rx_byte;
    logic       o_rx_byte_valid;
    logic       o_rx_err;
    logic       o_busy;

    modport master (
        input  i_rx,
        output o_rx_byte, o_rx_byte_valid, o_rx_err, o_busy
    );

    modport slave (
        output i_rx,
        input  o_rx_byte, o_rx_byte_valid, o_rx_err, o_busy
    );
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver with mid-bit sampling and valid/error pulses
// Define UART_RX_PARITY_EN for 8E1 frames (even parity checked before the stop bit)
module uart_rx_deser #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int SYNC_STAGES = 2
) (
    input logic             i_clk,
    input logic             i_rst,
    uart_rx_deser_if.master rx_if
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_baud_chk
        $error("uart_rx_deser: CLKS_PER_BIT must be at least 4");
    end
    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("uart_rx_deser: SYNC_STAGES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q, byte_q;
    logic                   valid_q, err_q, busy_q;
    logic                   rx_s, tick, par_fault;

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    assign par_fault = par_err_q;
`else
    assign par_fault = 1'b0;
`endif

    // START samples at half a bit; every later sample is one full bit on, i.e. mid-bit
    always_comb begin
        tick   = baud_q == (state_q == START ? MID : LAST);
        baud_d = (state_q == IDLE || state_q == BREAK || tick) ? '0 : baud_q + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '1;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_if.i_rx};
            baud_q  <= baud_d;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_q <= START;
                    busy_q  <= 1'b1;
                end
                START: if (tick) begin
                    state_q <= rx_s ? IDLE : DATA;
                    busy_q  <= !rx_s;
                end
                DATA: if (tick) begin
                    shift_q <= {rx_s, shift_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == 3'd7) state_q <= PARITY;
`else
                    if (bit_q == 3'd7) state_q <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    par_err_q <= rx_s ^ (^shift_q);
                    state_q   <= STOP;
                end
`endif
                // Leaving at mid-stop keeps half a bit of margin for a back-to-back start edge
                STOP: if (tick) begin
                    state_q <= rx_s ? IDLE : BREAK;
                    busy_q  <= !rx_s;
                    valid_q <= rx_s && !par_fault;
                    err_q   <= !rx_s || par_fault;
                    if (rx_s && !par_fault) byte_q <= shift_q;
                end
                BREAK: if (rx_s) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.o_rx_byte       = byte_q;
    assign rx_if.o_rx_byte_valid = valid_q;
    assign rx_if.o_rx_err        = err_q;
    assign rx_if.o_busy          = busy_q;
endmodule
